draw_playground_fx: RTL and testbench

- Parametrised, pipelined successor of the playground renderer: draws field border, centre line, centre ring and both goals over the incoming background video.
- Adds a goal-flash animation FSM: on a goal event, the scoring side's goal frame blinks for a configurable number of frames.
- Sits in the VGA pixel chain between the background generator and the puck/mallet overlay stages.
- Passes the timing bus through with fixed latency.

---
 rtl/draw_playground_fx.sv | 211 +++++++++++++++++++++
 tb/tb_draw_playground_fx.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/draw_playground_fx.sv
// Playground overlay: draws field outline, centre line, centre ring and goals over background video,
// with a goal-flash animation. Two-stage pipeline, video outputs lag inputs by exactly two cycles.
module draw_playground_fx #(
  parameter int          H_RES        = 1024,
  parameter int          V_RES        = 768,
  parameter int          BORDER       = 39,
  parameter int          LINE_W       = 8,
  parameter int          R_IN_SQ      = 13080,
  parameter int          R_OUT_SQ     = 15000,
  parameter int          GOAL_Y0      = 258,
  parameter int          GOAL_Y1      = 458,
  parameter logic [11:0] LINE_COLOUR  = 12'hfff,
  parameter logic [11:0] FLASH_COLOUR = 12'hf00,
  parameter int          FLASH_PERIOD = 8,
  parameter int          FLASH_FRAMES = 60
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic [11:0] hcount_in,
  input  logic [11:0] vcount_in,
  input  logic        hsync_in,
  input  logic        hblnk_in,
  input  logic        vsync_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic        goal_left,
  input  logic        goal_right,
  output logic [11:0] hcount_out,
  output logic [11:0] vcount_out,
  output logic        hsync_out,
  output logic        hblnk_out,
  output logic        vsync_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out,
  output logic        flash_busy
);

  localparam int CX  = H_RES / 2;
  localparam int CY  = V_RES / 2;
  localparam int X_L = BORDER;
  localparam int X_R = H_RES - 1 - BORDER;
  localparam int Y_T = BORDER;
  localparam int Y_B = V_RES - 1 - BORDER;
  localparam int FCW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
  localparam int PCW = (FLASH_PERIOD > 1) ? $clog2(FLASH_PERIOD) : 1;
  localparam logic signed [12:0] CX_S = 13'(CX);
  localparam logic signed [12:0] CY_S = 13'(CY);

  typedef enum logic [1:0] {IDLE = 2'd0, FLASH_L = 2'd1, FLASH_R = 2'd2} state_t;

  function automatic logic in_rng(input logic [11:0] v, input int lo, input int hi);
    return (int'(v) >= lo) && (int'(v) <= hi);
  endfunction

  logic signed [12:0] dx_s, dy_s;
  logic [12:0] dx_mag_s, dy_mag_s;
  logic [23:0] dx2_s, dy2_s;
  logic goal_l_s, goal_r_s, outline_s, centre_s;

  logic [11:0] hcount_d1_r, vcount_d1_r, rgb_d1_r;
  logic hsync_d1_r, hblnk_d1_r, vsync_d1_r, vblnk_d1_r;
  logic [23:0] dx2_r, dy2_r;
  logic goal_l_r, goal_r_r, outline_r, centre_r;

  logic [11:0] hcount_r, vcount_r, rgb_r;
  logic hsync_r, hblnk_r, vsync_r, vblnk_r, flash_busy_r;

  state_t state_r, state_next_s;
  logic [FCW-1:0] frame_cnt_r, frame_cnt_next_s;
  logic [PCW-1:0] period_cnt_r, period_cnt_next_s;
  logic phase_r, phase_next_s, vsync_prev_r, tick_s;

  logic [24:0] sum_s;
  logic ring_s;
  logic [11:0] goal_l_col_s, goal_r_col_s, rgb_next_s;

  // Stage-1 combinational geometry: centre offsets, squares and region flags
  always_comb begin
    dx_s     = $signed({1'b0, hcount_in}) - CX_S;
    dy_s     = $signed({1'b0, vcount_in}) - CY_S;
    dx_mag_s = dx_s[12] ? $unsigned(-dx_s) : $unsigned(dx_s);
    dy_mag_s = dy_s[12] ? $unsigned(-dy_s) : $unsigned(dy_s);
    dx2_s    = 24'(dx_mag_s) * 24'(dx_mag_s);
    dy2_s    = 24'(dy_mag_s) * 24'(dy_mag_s);
    goal_l_s = (in_rng(hcount_in, 0, LINE_W - 1) && in_rng(vcount_in, GOAL_Y0, GOAL_Y1)) ||
               (in_rng(hcount_in, 0, BORDER) &&
                (in_rng(vcount_in, GOAL_Y0, GOAL_Y0 + LINE_W - 1) ||
                 in_rng(vcount_in, GOAL_Y1 - LINE_W + 1, GOAL_Y1)));
    goal_r_s = (in_rng(hcount_in, H_RES - LINE_W, H_RES - 1) && in_rng(vcount_in, GOAL_Y0, GOAL_Y1)) ||
               (in_rng(hcount_in, H_RES - 1 - BORDER, H_RES - 1) &&
                (in_rng(vcount_in, GOAL_Y0, GOAL_Y0 + LINE_W - 1) ||
                 in_rng(vcount_in, GOAL_Y1 - LINE_W + 1, GOAL_Y1)));
    outline_s = (in_rng(vcount_in, Y_T, Y_B) &&
                 (in_rng(hcount_in, X_L, X_L + LINE_W - 1) || in_rng(hcount_in, X_R - LINE_W + 1, X_R))) ||
                (in_rng(hcount_in, X_L, X_R) &&
                 (in_rng(vcount_in, Y_T, Y_T + LINE_W - 1) || in_rng(vcount_in, Y_B - LINE_W + 1, Y_B)));
    centre_s = in_rng(hcount_in, CX - LINE_W / 2, CX + LINE_W / 2 - 1) && in_rng(vcount_in, Y_T, Y_B);
  end

  // Stage-1 pipeline registers
  always_ff @(posedge clk_in) begin
    if (rst) begin
      hcount_d1_r <= 12'd0; vcount_d1_r <= 12'd0; rgb_d1_r <= 12'd0;
      hsync_d1_r  <= 1'b0;  hblnk_d1_r  <= 1'b0;  vsync_d1_r <= 1'b0; vblnk_d1_r <= 1'b0;
      dx2_r       <= 24'd0; dy2_r       <= 24'd0;
      goal_l_r    <= 1'b0;  goal_r_r    <= 1'b0;  outline_r  <= 1'b0; centre_r   <= 1'b0;
    end else begin
      hcount_d1_r <= hcount_in; vcount_d1_r <= vcount_in; rgb_d1_r <= rgb_in;
      hsync_d1_r  <= hsync_in;  hblnk_d1_r  <= hblnk_in;  vsync_d1_r <= vsync_in; vblnk_d1_r <= vblnk_in;
      dx2_r       <= dx2_s;     dy2_r       <= dy2_s;
      goal_l_r    <= goal_l_s;  goal_r_r    <= goal_r_s;  outline_r  <= outline_s; centre_r <= centre_s;
    end
  end

  // Flash FSM next state: goal events restart the sequence, frame ticks advance it
  always_comb begin
    tick_s            = vsync_in & ~vsync_prev_r;
    state_next_s      = state_r;
    frame_cnt_next_s  = frame_cnt_r;
    period_cnt_next_s = period_cnt_r;
    phase_next_s      = phase_r;
    if (goal_left || goal_right) begin
      state_next_s      = goal_left ? FLASH_L : FLASH_R;
      frame_cnt_next_s  = {FCW{1'b0}};
      period_cnt_next_s = {PCW{1'b0}};
      phase_next_s      = 1'b0;
    end else begin
      case (state_r)
        IDLE: state_next_s = IDLE;
        FLASH_L, FLASH_R: begin
          if (tick_s && (frame_cnt_r == FCW'(FLASH_FRAMES - 1))) begin
            state_next_s      = IDLE;
            frame_cnt_next_s  = {FCW{1'b0}};
            period_cnt_next_s = {PCW{1'b0}};
            phase_next_s      = 1'b0;
          end else if (tick_s) begin
            frame_cnt_next_s = frame_cnt_r + FCW'(1);
            if (period_cnt_r == PCW'(FLASH_PERIOD - 1)) begin
              period_cnt_next_s = {PCW{1'b0}};
              phase_next_s      = ~phase_r;
            end else begin
              period_cnt_next_s = period_cnt_r + PCW'(1);
            end
          end else begin
            state_next_s = state_r;
          end
        end
        default: begin
          state_next_s      = IDLE;
          frame_cnt_next_s  = {FCW{1'b0}};
          period_cnt_next_s = {PCW{1'b0}};
          phase_next_s      = 1'b0;
        end
      endcase
    end
  end

  // Flash FSM state and counters
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_r      <= IDLE;
      frame_cnt_r  <= {FCW{1'b0}};
      period_cnt_r <= {PCW{1'b0}};
      phase_r      <= 1'b0;
      vsync_prev_r <= 1'b0;
      flash_busy_r <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      frame_cnt_r  <= frame_cnt_next_s;
      period_cnt_r <= period_cnt_next_s;
      phase_r      <= phase_next_s;
      vsync_prev_r <= vsync_in;
      flash_busy_r <= (state_next_s != IDLE);
    end
  end

  // Stage-2 ring test and priority colour select
  always_comb begin
    sum_s        = {1'b0, dx2_r} + {1'b0, dy2_r};
    ring_s       = (sum_s >= 25'(R_IN_SQ)) && (sum_s <= 25'(R_OUT_SQ));
    goal_l_col_s = ((state_r == FLASH_L) && !phase_r) ? FLASH_COLOUR : LINE_COLOUR;
    goal_r_col_s = ((state_r == FLASH_R) && !phase_r) ? FLASH_COLOUR : LINE_COLOUR;
    if (hblnk_d1_r || vblnk_d1_r)        rgb_next_s = 12'h000;
    else if (goal_l_r)                   rgb_next_s = goal_l_col_s;
    else if (goal_r_r)                   rgb_next_s = goal_r_col_s;
    else if (outline_r || centre_r)      rgb_next_s = LINE_COLOUR;
    else if (ring_s)                     rgb_next_s = LINE_COLOUR;
    else                                 rgb_next_s = rgb_d1_r;
  end

  // Stage-2 output registers
  always_ff @(posedge clk_in) begin
    if (rst) begin
      hcount_r <= 12'd0; vcount_r <= 12'd0; rgb_r <= 12'd0;
      hsync_r  <= 1'b0;  hblnk_r  <= 1'b0;  vsync_r <= 1'b0; vblnk_r <= 1'b0;
    end else begin
      hcount_r <= hcount_d1_r; vcount_r <= vcount_d1_r; rgb_r <= rgb_next_s;
      hsync_r  <= hsync_d1_r;  hblnk_r  <= hblnk_d1_r;  vsync_r <= vsync_d1_r; vblnk_r <= vblnk_d1_r;
    end
  end

  assign hcount_out = hcount_r;
  assign vcount_out = vcount_r;
  assign hsync_out  = hsync_r;
  assign hblnk_out  = hblnk_r;
  assign vsync_out  = vsync_r;
  assign vblnk_out  = vblnk_r;
  assign rgb_out    = rgb_r;
  assign flash_busy = flash_busy_r;

endmodule

// File: tb/tb_draw_playground_fx.sv
// Randomized scoreboard bench for draw_playground_fx against a frame-level reference model.
module tb_draw_playground_fx;

  localparam int H_RES = 1024, V_RES = 768, BORDER = 39, LINE_W = 8;
  localparam int R_IN_SQ = 13080, R_OUT_SQ = 15000, GOAL_Y0 = 258, GOAL_Y1 = 458;
  localparam logic [11:0] LINE_COLOUR = 12'hfff, FLASH_COLOUR = 12'hf00;
  localparam int FLASH_PERIOD = 8, FLASH_FRAMES = 60, FRAME_LEN = 16;

  logic clk_in = 1'b0;
  logic rst = 1'b1;
  logic [11:0] hcount_in = 12'd0, vcount_in = 12'd0, rgb_in = 12'd0;
  logic hsync_in = 1'b0, hblnk_in = 1'b0, vsync_in = 1'b0, vblnk_in = 1'b0;
  logic goal_left = 1'b0, goal_right = 1'b0;
  logic [11:0] hcount_out, vcount_out, rgb_out;
  logic hsync_out, hblnk_out, vsync_out, vblnk_out, flash_busy;

  always #5 clk_in = ~clk_in;

  draw_playground_fx dut (
    .clk_in(clk_in), .rst(rst),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .hblnk_in(hblnk_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .goal_left(goal_left), .goal_right(goal_right),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .hblnk_out(hblnk_out), .vsync_out(vsync_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out), .flash_busy(flash_busy)
  );

  typedef struct {
    logic [11:0] h, v, rgb;
    logic hs, hb, vs, vb, busy;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int n_vec = 0, n_bad = 0, cyc = 0;
  int side = 0, nfr = 0;   // side: 0 none, 1 left, 2 right; nfr: frames since goal
  bit prev_vs = 1'b0;

  int pts_x[24] = '{627, 622, 640, 39, 47, 512, 3, 1020, 20, 39, 40, 1000,
                    984, 983, 508, 515, 507, 516, 0, 1023, 684, 46, 977, 39};
  int pts_y[24] = '{384, 384, 384, 100, 100, 300, 300, 300, 258, 262, 262, 455,
                    458, 458, 39, 728, 300, 300, 0, 767, 728, 300, 300, 38};

  function automatic bit in_r(int v, int lo, int hi);
    return (v >= lo) && (v <= hi);
  endfunction

  function automatic bit is_goal(int x, int y);
    return (x >= 0 && x < LINE_W && in_r(y, GOAL_Y0, GOAL_Y1)) ||
           (x >= 0 && x <= BORDER && (in_r(y, GOAL_Y0, GOAL_Y0 + LINE_W - 1) ||
                                      in_r(y, GOAL_Y1 - LINE_W + 1, GOAL_Y1)));
  endfunction

  function automatic logic [11:0] model_rgb(int x, int y, bit blank, logic [11:0] bg);
    int xl = BORDER, xr = H_RES - 1 - BORDER, yt = BORDER, yb = V_RES - 1 - BORDER;
    int dx = x - H_RES / 2, dy = y - V_RES / 2;
    bit blink_on = ((nfr / FLASH_PERIOD) % 2) == 0;
    if (blank) return 12'h000;
    if (is_goal(x, y)) return (side == 1 && blink_on) ? FLASH_COLOUR : LINE_COLOUR;
    if (is_goal(H_RES - 1 - x, y)) return (side == 2 && blink_on) ? FLASH_COLOUR : LINE_COLOUR;
    if (in_r(y, yt, yb) && (in_r(x, xl, xl + LINE_W - 1) || in_r(x, xr - LINE_W + 1, xr))) return LINE_COLOUR;
    if (in_r(x, xl, xr) && (in_r(y, yt, yt + LINE_W - 1) || in_r(y, yb - LINE_W + 1, yb))) return LINE_COLOUR;
    if (in_r(x, H_RES / 2 - LINE_W / 2, H_RES / 2 + LINE_W / 2 - 1) && in_r(y, yt, yb)) return LINE_COLOUR;
    if (in_r(dx * dx + dy * dy, R_IN_SQ, R_OUT_SQ)) return LINE_COLOUR;
    return bg;
  endfunction

  task automatic step(input bit r, input bit gl, input bit gr);
    exp_t e, last;
    int x, y, k;
    bit vs;
    if ($urandom_range(0, 1) == 1) begin
      k = $urandom_range(0, 23); x = pts_x[k]; y = pts_y[k];
    end else begin
      x = $urandom_range(0, H_RES - 1); y = $urandom_range(0, V_RES - 1);
    end
    vs = (cyc % FRAME_LEN) < 2;
    rst = r; goal_left = gl; goal_right = gr;
    hcount_in = 12'(x); vcount_in = 12'(y); rgb_in = 12'($urandom_range(0, 4095));
    hsync_in = 1'($urandom_range(0, 1)); vsync_in = vs;
    hblnk_in = ($urandom_range(0, 7) == 0); vblnk_in = ($urandom_range(0, 7) == 0);
    if (r) begin
      side = 0; nfr = 0; prev_vs = 1'b0;
    end else begin
      if (gl) begin side = 1; nfr = 0; end
      else if (gr) begin side = 2; nfr = 0; end
      else if (vs && !prev_vs && side != 0) begin
        nfr++;
        if (nfr == FLASH_FRAMES) begin side = 0; nfr = 0; end
      end
      prev_vs = vs;
    end
    // previous pixel leaves the pipe one edge later: it sees this cycle's reset and busy state
    if (exp_q.size() > 0) begin
      last = exp_q.pop_back();
      if (r) begin
        last.h = 12'd0; last.v = 12'd0; last.rgb = 12'd0;
        last.hs = 1'b0; last.hb = 1'b0; last.vs = 1'b0; last.vb = 1'b0;
      end
      last.busy = (side != 0);
      exp_q.push_back(last);
    end
    if (r) begin
      e.h = 12'd0; e.v = 12'd0; e.rgb = 12'd0;
      e.hs = 1'b0; e.hb = 1'b0; e.vs = 1'b0; e.vb = 1'b0;
    end else begin
      e.h = hcount_in; e.v = vcount_in; e.hs = hsync_in; e.hb = hblnk_in; e.vs = vs; e.vb = vblnk_in;
      e.rgb = model_rgb(x, y, hblnk_in | vblnk_in, rgb_in);
    end
    e.busy = 1'b0;
    exp_q.push_back(e);
    @(posedge clk_in);
    #1;
    cyc++;
  endtask

  task automatic align_mid_frame();
    while ((cyc % FRAME_LEN) != FRAME_LEN / 2) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_reset_state(input string tag);
    if ({hcount_out, vcount_out, rgb_out, hsync_out, hblnk_out, vsync_out, vblnk_out, flash_busy} !== 42'd0) begin
      n_bad++;
      $display("FAIL %s: outputs not zero during reset: h=%0d v=%0d rgb=%h sync/blank=%b%b%b%b busy=%b",
               tag, hcount_out, vcount_out, rgb_out, hsync_out, hblnk_out, vsync_out, vblnk_out, flash_busy);
    end
  endtask

  // Monitor: every output pixel is compared with the oldest queued expectation
  always @(negedge clk_in) begin
    if (exp_q.size() >= 3) begin
      mon_e = exp_q.pop_front();
      n_vec++;
      if ({hcount_out, vcount_out, rgb_out, hsync_out, hblnk_out, vsync_out, vblnk_out, flash_busy} !==
          {mon_e.h, mon_e.v, mon_e.rgb, mon_e.hs, mon_e.hb, mon_e.vs, mon_e.vb, mon_e.busy}) begin
        n_bad++;
        $display("FAIL pixel #%0d: got h=%0d v=%0d rgb=%h sync/blank=%b%b%b%b busy=%b, need h=%0d v=%0d rgb=%h sync/blank=%b%b%b%b busy=%b",
                 n_vec, hcount_out, vcount_out, rgb_out, hsync_out, hblnk_out, vsync_out, vblnk_out, flash_busy,
                 mon_e.h, mon_e.v, mon_e.rgb, mon_e.hs, mon_e.hb, mon_e.vs, mon_e.vb, mon_e.busy);
      end
    end
  end

  initial begin
    repeat (5) step(1'b1, 1'b0, 1'b0);
    check_reset_state("initial reset");
    repeat (100) step(1'b0, 1'b0, 1'b0);
    align_mid_frame();
    step(1'b0, 1'b1, 1'b0);
    repeat (62 * FRAME_LEN) step(1'b0, 1'b0, 1'b0);
    if (flash_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL expired wait: flash_busy still high %0d frames after left goal", 62);
    end
    align_mid_frame();
    step(1'b0, 1'b1, 1'b1);
    repeat (20 * FRAME_LEN) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    repeat (30 * FRAME_LEN) step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    if ((flash_busy !== 1'b0) || (rgb_out !== 12'h000)) begin
      n_bad++;
      $display("FAIL mid-flash reset: busy=%b rgb=%h one cycle after rst", flash_busy, rgb_out);
    end
    repeat (2) step(1'b1, 1'b0, 1'b0);
    check_reset_state("mid-flash reset");
    repeat (100) step(1'b0, 1'b0, 1'b0);
    repeat (4) @(negedge clk_in);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
